// File: rtl/axi_rd_arbiter_if.sv
// AXI4 read-channel bundle (AR + R) shared by the fetch, load/store and memory ports.
// The master modport is the side that issues addresses and consumes read data.
interface axi_rd_arbiter_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int ID_WIDTH    = 4,
    parameter int ALEN        = 8,
    parameter int ASIZE       = 3,
    parameter int ABURST      = 2,
    parameter int ACERR_WIDTH = 2
) ();
    logic [DATA_WIDTH-1:0]  araddr;
    logic [ID_WIDTH-1:0]    arid;
    logic [ALEN-1:0]        arlen;
    logic [ASIZE-1:0]       arsize;
    logic [ABURST-1:0]      arburst;
    logic                   arvalid;
    logic                   arready;
    logic [DATA_WIDTH-1:0]  rdata;
    logic [ACERR_WIDTH-1:0] rresp;
    logic                   rlast;
    logic                   rvalid;
    logic                   rready;

    modport master (
        output araddr, arid, arlen, arsize, arburst, arvalid, rready,
        input  arready, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  araddr, arid, arlen, arsize, arburst, arvalid, rready,
        output arready, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Two-master round-robin AXI4 read arbiter: IFU (master 0) and LSU (master 1) share one
// slave read port; a grant covers one whole transaction from AR handshake to last beat.
module axi_rd_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int ID_WIDTH    = 4,
    parameter int ALEN        = 8,
    parameter int ASIZE       = 3,
    parameter int ABURST      = 2,
    parameter int ACERR_WIDTH = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ifu_req,
    input  logic              lsu_req,
    output logic              ifu_grant,
    output logic              lsu_grant,
    axi_rd_arbiter_if.slave   ifu,
    axi_rd_arbiter_if.slave   lsu,
    axi_rd_arbiter_if.master  s,
    output logic              rd_err,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t            state_reg, state_next;
    logic              owner_reg, owner_next;   // 0 = IFU, 1 = LSU
    logic              last_reg, last_next;     // master served most recently
    logic [ALEN-1:0]   cnt_reg, cnt_next;
    logic              rd_err_reg, rd_err_next;

    logic [DATA_WIDTH-1:0]  g_araddr;
    logic [ID_WIDTH-1:0]    g_arid;
    logic [ALEN-1:0]        g_arlen;
    logic [ASIZE-1:0]       g_arsize;
    logic [ABURST-1:0]      g_arburst;
    logic [ACERR_WIDTH-1:0] g_rresp;
    logic                   g_req, g_arvalid, g_rready;
    logic                   ar_hs, r_hs;

    // Owner-selected view of the two masters; only meaningful while busy.
    always_comb begin
        g_araddr  = owner_reg ? lsu.araddr  : ifu.araddr;
        g_arid    = owner_reg ? lsu.arid    : ifu.arid;
        g_arlen   = owner_reg ? lsu.arlen   : ifu.arlen;
        g_arsize  = owner_reg ? lsu.arsize  : ifu.arsize;
        g_arburst = owner_reg ? lsu.arburst : ifu.arburst;
        g_req     = owner_reg ? lsu_req     : ifu_req;
        g_arvalid = owner_reg ? lsu.arvalid : ifu.arvalid;
        g_rready  = owner_reg ? lsu.rready  : ifu.rready;
    end

    assign g_rresp = s.rresp;
    assign ar_hs   = (state_reg == ADDR) && g_arvalid && s.arready;
    assign r_hs    = (state_reg == DATA) && s.rvalid && g_rready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg  <= IDLE;
            owner_reg  <= 1'b0;
            last_reg   <= 1'b0;
            cnt_reg    <= '0;
            rd_err_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            owner_reg  <= owner_next;
            last_reg   <= last_next;
            cnt_reg    <= cnt_next;
            rd_err_reg <= rd_err_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        owner_next  = owner_reg;
        last_next   = last_reg;
        cnt_next    = cnt_reg;
        rd_err_next = r_hs && (g_rresp != '0);
        case (state_reg)
            IDLE: begin
                if (ifu_req || lsu_req) begin
                    state_next = ADDR;
                    owner_next = (ifu_req && lsu_req) ? ~last_reg : lsu_req;
                end
            end
            ADDR: begin
                if (ar_hs) begin
                    state_next = DATA;
                    cnt_next   = g_arlen;
                end else if (!g_req && !g_arvalid) begin
                    // Request withdrawn before issue: release without counting it as served.
                    state_next = IDLE;
                end
            end
            DATA: begin
                if (r_hs) begin
                    // Counter exhaustion closes the burst even if the slave never flags rlast.
                    if (s.rlast || (cnt_reg == '0)) begin
                        state_next = IDLE;
                        last_next  = owner_reg;
                    end else begin
                        cnt_next = cnt_reg - ALEN'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy      = (state_reg != IDLE);
    assign ifu_grant = busy && !owner_reg;
    assign lsu_grant = busy &&  owner_reg;
    assign rd_err    = rd_err_reg;

    assign s.araddr  = g_araddr;
    assign s.arid    = g_arid;
    assign s.arlen   = g_arlen;
    assign s.arsize  = g_arsize;
    assign s.arburst = g_arburst;
    assign s.arvalid = (state_reg == ADDR) && g_arvalid;
    assign s.rready  = (state_reg == DATA) && g_rready;

    assign ifu.arready = (state_reg == ADDR) && !owner_reg && s.arready;
    assign lsu.arready = (state_reg == ADDR) &&  owner_reg && s.arready;
    assign ifu.rvalid  = (state_reg == DATA) && !owner_reg && s.rvalid;
    assign lsu.rvalid  = (state_reg == DATA) &&  owner_reg && s.rvalid;

    // Data lanes are broadcast; rvalid alone decides which master sees a beat.
    assign ifu.rdata = s.rdata;
    assign ifu.rresp = s.rresp;
    assign ifu.rlast = s.rlast;
    assign lsu.rdata = s.rdata;
    assign lsu.rresp = s.rresp;
    assign lsu.rlast = s.rlast;
endmodule
